// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one 32-bit carry-select adder among NREQ requesters, with chained multi-beat bursts.
// Latency: 1 cycle. A handshake at one edge is presented on rsp_* right after that edge.
// Backpressure: a held response (rsp_valid & !rsp_ready) drops every req_ready and freezes all state.
module adder_share_arbiter #(
    parameter int NREQ      = 4,
    parameter int MAX_BEATS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    input  logic [NREQ-1:0]      req_sub,
    input  logic [NREQ-1:0]      req_last,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [$clog2(NREQ)-1:0]      rsp_id,
    output logic [$clog2(MAX_BEATS)-1:0] rsp_beat,
    output logic [31:0]          rsp_result,
    output logic                 rsp_cout,
    output logic                 rsp_overflow,
    output logic                 rsp_last,
    output logic                 rsp_err,
    output logic                 busy
);
    localparam int IDW = $clog2(NREQ);
    localparam int BW  = $clog2(MAX_BEATS);

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  owner;
    logic [BW-1:0]   cnt;
    logic            carry_reg;
    logic            sub_reg;

    logic            can_take;
    logic            grant_vld;
    logic [IDW-1:0]  grant;
    logic [IDW-1:0]  sel;
    logic            sel_vld;
    logic            hs;
    logic            sub_eff;
    logic            forced;
    logic            beat_last;

    logic [31:0]     op_a;
    logic [31:0]     op_b;
    logic            cin;
    logic [16:0]     lo_s;
    logic [16:0]     hi0_s;
    logic [16:0]     hi1_s;
    logic [31:0]     sum;
    logic            cout;
    logic            ovf;

    assign can_take = !rsp_valid || rsp_ready;

    // Highest priority goes to the requester just after the last one served.
    always_comb begin
        grant_vld = 1'b0;
        grant     = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req_valid[IDW'((int'(rr_ptr) + k) % NREQ)]) begin
                grant_vld = 1'b1;
                grant     = IDW'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

    assign sel     = (state == BURST) ? owner : grant;
    assign sel_vld = (state == BURST) ? req_valid[owner] : grant_vld;
    assign hs      = sel_vld && can_take;
    assign sub_eff = (state == BURST) ? sub_reg : req_sub[sel];
    assign cin     = (state == BURST) ? carry_reg : req_sub[sel];
    assign forced  = (state == BURST) && (cnt == BW'(MAX_BEATS - 1));
    assign beat_last = req_last[sel];

    always_comb begin
        req_ready = '0;
        if (hs) req_ready[sel] = 1'b1;
    end

    assign op_a = req_a[{sel, 5'b0} +: 32];
    assign op_b = sub_eff ? ~req_b[{sel, 5'b0} +: 32] : req_b[{sel, 5'b0} +: 32];

    // Carry-select: both upper-half sums are formed in parallel, the low carry picks one.
    assign lo_s  = {1'b0, op_a[15:0]} + {1'b0, op_b[15:0]} + {16'b0, cin};
    assign hi0_s = {1'b0, op_a[31:16]} + {1'b0, op_b[31:16]};
    assign hi1_s = {1'b0, op_a[31:16]} + {1'b0, op_b[31:16]} + 17'd1;
    assign sum   = {lo_s[16] ? hi1_s[15:0] : hi0_s[15:0], lo_s[15:0]};
    assign cout  = lo_s[16] ? hi1_s[16] : hi0_s[16];
    assign ovf   = (op_a[31] == op_b[31]) && (sum[31] != op_a[31]);

    assign busy = (state == BURST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= IDW'(NREQ - 1);
            owner        <= '0;
            cnt          <= '0;
            carry_reg    <= 1'b0;
            sub_reg      <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_beat     <= '0;
            rsp_result   <= '0;
            rsp_cout     <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_last     <= 1'b0;
            rsp_err      <= 1'b0;
        end else begin
            if (hs) begin
                rsp_valid    <= 1'b1;
                rsp_id       <= sel;
                rsp_beat     <= (state == BURST) ? cnt : '0;
                rsp_result   <= sum;
                rsp_cout     <= cout;
                rsp_overflow <= ovf;
                rsp_last     <= beat_last | forced;
                rsp_err      <= forced & !beat_last;
                carry_reg    <= cout;
                if (state == IDLE) begin
                    sub_reg <= req_sub[sel];
                    if (beat_last) begin
                        rr_ptr <= sel;
                    end else begin
                        owner <= sel;
                        cnt   <= BW'(1);
                        state <= BURST;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                    if (beat_last || forced) begin
                        state  <= IDLE;
                        rr_ptr <= owner;
                        cnt    <= '0;
                    end
                end
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter: single-beat vector table plus burst, fairness,
// backpressure, forced-termination and reset-mid-burst sequences.
module tb_adder_share_arbiter;
    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   req_sub;
    logic [3:0]   req_last;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [1:0]   rsp_beat;
    logic [31:0]  rsp_result;
    logic         rsp_cout;
    logic         rsp_overflow;
    logic         rsp_last;
    logic         rsp_err;
    logic         busy;

    logic [31:0]  a_arr [4];
    logic [31:0]  b_arr [4];

    int n_cmp = 0;
    int n_bad = 0;

    assign req_a = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};
    assign req_b = {b_arr[3], b_arr[2], b_arr[1], b_arr[0]};

    adder_share_arbiter #(.NREQ(4), .MAX_BEATS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .req_last(req_last),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_beat(rsp_beat), .rsp_result(rsp_result),
        .rsp_cout(rsp_cout), .rsp_overflow(rsp_overflow),
        .rsp_last(rsp_last), .rsp_err(rsp_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] res;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] id, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic last);
        req_valid[id] = 1'b1;
        a_arr[id]     = a;
        b_arr[id]     = b;
        req_sub[id]   = sub;
        req_last[id]  = last;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_sub   = '0;
        req_last  = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_arr[i] = '0;
            b_arr[i] = '0;
        end

        vecs[0] = '{2'd0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[1] = '{2'd3, 32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[2] = '{2'd1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[3] = '{2'd2, 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        vecs[4] = '{2'd0, 32'h0000000A, 32'h0000000A, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vecs[5] = '{2'd1, 32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b0};
        vecs[6] = '{2'd2, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1};

        #12;
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_result", 64'(rsp_result), 64'd0);
        chk("reset_last_err", 64'({rsp_last, rsp_err}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fairness: everyone valid with single beats from reset.
        for (int i = 0; i < 4; i++) drive(2'(i), 32'(i), 32'h10, 1'b0, 1'b1);
        #1;
        chk("rr_first_ready", 64'(req_ready), 64'b0001);
        for (int k = 0; k < 5; k++) begin
            tick;
            chk("rr_id", 64'(rsp_id), 64'(k % 4));
            chk("rr_result", 64'(rsp_result), 64'((k % 4) + 16));
        end
        req_valid = '0;

        // Single-beat vector table.
        for (int v = 0; v < 7; v++) begin
            drive(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].sub, 1'b1);
            #1;
            chk("vec_ready", 64'(req_ready), 64'(4'b0001 << vecs[v].id));
            tick;
            req_valid = '0;
            chk("vec_result", 64'(rsp_result), 64'(vecs[v].res));
            chk("vec_cout_ovf", 64'({rsp_cout, rsp_overflow}), 64'({vecs[v].cout, vecs[v].ovf}));
            chk("vec_meta", 64'({rsp_valid, rsp_id, rsp_beat, rsp_last, rsp_err}),
                64'({1'b1, vecs[v].id, 2'd0, 1'b1, 1'b0}));
        end

        // Burst on req2 with req1 waiting; last vector served id2, so serve id1 first to point past it.
        drive(2'd1, 32'd0, 32'd0, 1'b0, 1'b1);
        tick;
        req_valid = '0;
        drive(2'd2, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
        drive(2'd1, 32'd3, 32'd4, 1'b0, 1'b1);
        #1;
        chk("burst_b0_ready", 64'(req_ready), 64'b0100);
        tick;
        chk("burst_b0", 64'({rsp_result, rsp_cout, rsp_beat, rsp_last, rsp_id}),
            64'({32'h0, 1'b1, 2'd0, 1'b0, 2'd2}));
        chk("burst_busy", 64'(busy), 64'd1);
        drive(2'd2, 32'h0, 32'h0, 1'b1, 1'b1);
        #1;
        chk("burst_b1_ready", 64'(req_ready), 64'b0100);
        tick;
        chk("burst_b1", 64'({rsp_result, rsp_cout, rsp_beat, rsp_last, rsp_id}),
            64'({32'h1, 1'b0, 2'd1, 1'b1, 2'd2}));
        chk("burst_idle", 64'(busy), 64'd0);
        req_valid[2] = 1'b0;
        #1;
        chk("after_burst_ready", 64'(req_ready), 64'b0010);
        tick;
        req_valid = '0;
        chk("after_burst_rsp", 64'({rsp_id, rsp_result}), 64'({2'd1, 32'd7}));

        // Backpressure.
        drive(2'd0, 32'd50, 32'd5, 1'b0, 1'b1);
        tick;
        req_valid = '0;
        rsp_ready = 1'b0;
        drive(2'd3, 32'd100, 32'd1, 1'b0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_ready", 64'(req_ready), 64'd0);
            tick;
            chk("bp_hold", 64'({rsp_valid, rsp_id, rsp_result}), 64'({1'b1, 2'd0, 32'd55}));
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(req_ready), 64'b1000);
        tick;
        req_valid = '0;
        chk("bp_release_rsp", 64'({rsp_valid, rsp_id, rsp_result}), 64'({1'b1, 2'd3, 32'd101}));
        tick;
        chk("rsp_drain", 64'(rsp_valid), 64'd0);

        // Forced termination at MAX_BEATS.
        for (int b = 0; b < 4; b++) begin
            drive(2'd1, 32'(b + 1), 32'd0, 1'b0, 1'b0);
            tick;
            chk("forced_beat", 64'({rsp_id, rsp_beat, rsp_result}), 64'({2'd1, 2'(b), 32'(b + 1)}));
            chk("forced_last_err", 64'({rsp_last, rsp_err}), (b == 3) ? 64'b11 : 64'b00);
            chk("forced_busy", 64'(busy), (b == 3) ? 64'd0 : 64'd1);
        end
        req_valid = '0;
        tick;

        // Reset in the middle of a burst.
        drive(2'd2, 32'hFFFFFFFF, 32'h1, 1'b0, 1'b0);
        tick;
        req_valid = '0;
        chk("pre_reset_busy", 64'({busy, rsp_valid}), 64'b11);
        rst_n = 1'b0;
        #1;
        chk("midreset", 64'({busy, rsp_valid}), 64'b00);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        drive(2'd1, 32'd1, 32'd1, 1'b0, 1'b1);
        tick;
        req_valid = '0;
        chk("post_reset_sum", 64'({rsp_valid, rsp_result, rsp_cout}), 64'({1'b1, 32'd2, 1'b0}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
